// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-index types and constants for the register file and its
// pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down count with
// single-cycle overflow/underflow pulses when a step is refused.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Simultaneous inc and dec cancel, so neither pulse fires in that case.
  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    udf   = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (cnt_q == CNT_MAX) begin
          ovf = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (cnt_q == CNT_ZERO) begin
          udf = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-back port and pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-back to read forwarding.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic              rs1_en,
  input  logic              rs2_en,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_valid,
  input  logic              issue_regWrite,
  input  logic [4:0]        issue_rd,
  output logic              stall,
  input  logic              wb_regWrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              sb_overflow,
  output logic              sb_underflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  pend   [NREG];
  logic [NREG-1:0]   ovf_vec;
  logic [NREG-1:0]   udf_vec;
  logic              iss;
  logic              ret;
  logic              hazard1;
  logic              hazard2;
  logic              sb_overflow_d;
  logic              sb_overflow_q;
  logic              sb_underflow_d;
  logic              sb_underflow_q;

  // Issue is gated by stall, which never depends on the issue inputs.
  assign ret = wb_regWrite && (wb_rd != ZERO_REG);
  assign iss = issue_valid && issue_regWrite && (issue_rd != ZERO_REG) && !stall;

  always_comb begin
    regs_d = regs_q;
    if (ret) begin
      regs_d[wb_rd] = wb_data;
    end else begin
      regs_d[ZERO_REG] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign pend[0]    = CNT_ZERO;
  assign ovf_vec[0] = 1'b0;
  assign udf_vec[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (iss && (issue_rd == reg_idx_t'(i))),
      .dec (ret && (wb_rd == reg_idx_t'(i))),
      .cnt (pend[i]),
      .ovf (ovf_vec[i]),
      .udf (udf_vec[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic byp1;
  logic byp2;

  // The last outstanding producer retiring this cycle resolves the hazard.
  assign byp1     = ret && (wb_rd == rs1_addr);
  assign byp2     = ret && (wb_rd == rs2_addr);
  assign rs1_data = byp1 ? wb_data : regs_q[rs1_addr];
  assign rs2_data = byp2 ? wb_data : regs_q[rs2_addr];
  assign hazard1  = rs1_en && (rs1_addr != ZERO_REG) && (pend[rs1_addr] != CNT_ZERO)
                    && !(byp1 && (pend[rs1_addr] == CNT_ONE));
  assign hazard2  = rs2_en && (rs2_addr != ZERO_REG) && (pend[rs2_addr] != CNT_ZERO)
                    && !(byp2 && (pend[rs2_addr] == CNT_ONE));
`else
  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];
  assign hazard1  = rs1_en && (rs1_addr != ZERO_REG) && (pend[rs1_addr] != CNT_ZERO);
  assign hazard2  = rs2_en && (rs2_addr != ZERO_REG) && (pend[rs2_addr] != CNT_ZERO);
`endif

  assign stall = hazard1 | hazard2;

  always_comb begin
    sb_overflow_d  = sb_overflow_q  | (|ovf_vec);
    sb_underflow_d = sb_underflow_q | (|udf_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_overflow_q  <= 1'b0;
      sb_underflow_q <= 1'b0;
    end else begin
      sb_overflow_q  <= sb_overflow_d;
      sb_underflow_q <= sb_underflow_d;
    end
  end

  assign sb_overflow  = sb_overflow_q;
  assign sb_underflow = sb_underflow_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations follow
// REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_en, rs2_en;
  logic [31:0] rs1_data, rs2_data;
  logic        issue_valid, issue_regWrite;
  logic [4:0]  issue_rd;
  logic        stall;
  logic        wb_regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        sb_overflow, sb_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_regWrite(issue_regWrite), .issue_rd(issue_rd),
    .stall(stall),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .sb_overflow(sb_overflow), .sb_underflow(sb_underflow)
  );

  task automatic idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_en = 1'b0; rs2_en = 1'b0;
    issue_valid = 1'b0; issue_regWrite = 1'b0; issue_rd = 5'd0;
    wb_regWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    issue_valid = 1'b1; issue_regWrite = 1'b1; issue_rd = rd;
    tick();
  endtask

  task automatic retire(input logic [4:0] rd, input logic [31:0] d);
    idle();
    wb_regWrite = 1'b1; wb_rd = rd; wb_data = d;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd5;
    #1;
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL por_data: got %h expected %h", rs1_data, 32'h0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL por_stall: got %b expected 0", stall); end
    checks++; if ({sb_overflow, sb_underflow} !== 2'b00) begin errors++; $display("FAIL por_flags: got %b expected 00", {sb_overflow, sb_underflow}); end
    issue(5'd5);
    retire(5'd5, 32'h1234);
    issue(5'd5);
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd5;
    #1;
    checks++; if (rs1_data !== 32'h1234) begin errors++; $display("FAIL pre_rst_data: got %h expected %h", rs1_data, 32'h1234); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall: got %b expected 1", stall); end
    rst = 1'b1;
    #1;
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL async_rst_data: got %h expected %h", rs1_data, 32'h0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_rst_stall: got %b expected 0", stall); end
    checks++; if ({sb_overflow, sb_underflow} !== 2'b00) begin errors++; $display("FAIL async_rst_flags: got %b expected 00", {sb_overflow, sb_underflow}); end
    #1 rst = 1'b0;
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got %b expected 0", stall); end
  endtask

  task automatic test_basic_rw();
    issue(5'd3);
    retire(5'd3, 32'hDEADBEEF);
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    checks++; if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_x3_p1: got %h expected %h", rs1_data, 32'hDEADBEEF); end
    checks++; if (rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_x3_p2: got %h expected %h", rs2_data, 32'hDEADBEEF); end
    retire(5'd0, 32'hFFFFFFFF);
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_en = 1'b1; rs2_en = 1'b1;
    #1;
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL rd_x0_p1: got %h expected %h", rs1_data, 32'h0); end
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL rd_x0_p2: got %h expected %h", rs2_data, 32'h0); end
    checks++; if ({stall, sb_underflow} !== 2'b00) begin errors++; $display("FAIL x0_no_side_effect: got %b expected 00", {stall, sb_underflow}); end
  endtask

  task automatic test_raw_stall();
    issue(5'd7);
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", stall); end
    wb_regWrite = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_retire_stall: got %b expected 0", stall); end
    checks++; if (rs1_data !== 32'h55) begin errors++; $display("FAIL raw_bypass_data: got %h expected %h", rs1_data, 32'h55); end
`else
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_retire_stall: got %b expected 1", stall); end
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL raw_retire_data: got %h expected %h", rs1_data, 32'h0); end
`endif
    tick();
    wb_regWrite = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_after_stall: got %b expected 0", stall); end
    checks++; if (rs1_data !== 32'h55) begin errors++; $display("FAIL raw_after_data: got %h expected %h", rs1_data, 32'h55); end
  endtask

  task automatic test_simultaneous();
    issue(5'd9);
    idle();
    issue_valid = 1'b1; issue_regWrite = 1'b1; issue_rd = 5'd9;
    wb_regWrite = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    tick();
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd9;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL simul_stall: got %b expected 1", stall); end
    checks++; if (rs1_data !== 32'h99) begin errors++; $display("FAIL simul_data: got %h expected %h", rs1_data, 32'h99); end
    // Stalled issue of x10 must not create a pending write.
    issue_valid = 1'b1; issue_regWrite = 1'b1; issue_rd = 5'd10;
    tick();
    retire(5'd9, 32'hA9);
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd10; rs2_en = 1'b1; rs2_addr = 5'd9;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stalled_no_inc: got %b expected 0", stall); end
    checks++; if (rs2_data !== 32'hA9) begin errors++; $display("FAIL simul_final_data: got %h expected %h", rs2_data, 32'hA9); end
    checks++; if (sb_underflow !== 1'b0) begin errors++; $display("FAIL simul_underflow: got %b expected 0", sb_underflow); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) issue(5'd4);
    checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL sat_ovf_early: got %b expected 0", sb_overflow); end
    issue(5'd4);
    idle();
    #1;
    checks++; if (sb_overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", sb_overflow); end
    retire(5'd4, 32'h41);
    idle();
    rs2_en = 1'b0; rs2_addr = 5'd4;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL disabled_src: got %b expected 0", stall); end
    rs2_en = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL enabled_src: got %b expected 1", stall); end
    retire(5'd4, 32'h42);
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd4;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_pend1: got %b expected 1", stall); end
    retire(5'd4, 32'h43);
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd4;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_pend0: got %b expected 0", stall); end
    checks++; if (rs1_data !== 32'h43) begin errors++; $display("FAIL sat_data: got %h expected %h", rs1_data, 32'h43); end
    checks++; if (sb_underflow !== 1'b0) begin errors++; $display("FAIL udf_early: got %b expected 0", sb_underflow); end
    retire(5'd4, 32'h44);
    idle();
    tick();
    checks++; if ({sb_overflow, sb_underflow} !== 2'b11) begin errors++; $display("FAIL sticky_flags: got %b expected 11", {sb_overflow, sb_underflow}); end
  endtask

  task automatic test_reset_flags();
    rst = 1'b1;
    #1;
    checks++; if ({sb_overflow, sb_underflow} !== 2'b00) begin errors++; $display("FAIL flags_rst: got %b expected 00", {sb_overflow, sb_underflow}); end
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    test_reset();
    test_basic_rw();
    test_raw_stall();
    test_simultaneous();
    test_saturation();
    test_reset_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file with integrated write-back port and pending-write scoreboard for the 5-stage pipeline. It sits between decode and write-back. Write-back commits results presented by the MEM/WB stage. Decode reads two source operands and tracks in-flight destination writes. It asserts `stall` while a source register still has an uncommitted producer.

## Interface
- `DATA_W`, 32, register width
- `NREG`, 32, number of architectural registers (index 0 hardwired to zero)
- `CNT_W`, 2, width of per-register pending-write counter (max in-flight writes = 2^CNT_W − 1)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rs1_addr`, `rs2_addr`  in  5 each  decode source indices
- `rs1_en`, `rs2_en`  in  1 each  source actually consumed by the decoding instruction
- `rs1_data`, `rs2_data`  out  DATA_W each  operand read data (combinational)
- `issue_valid`  in  1  decode instruction advancing to EX this cycle (if not stalled)
- `issue_regWrite`  in  1  issued instruction writes a destination
- `issue_rd`  in  5  issued destination index
- `stall`  out  1  source hazard; decode must hold
- `wb_regWrite`  in  1  write-back commit enable (from MEM/WB)
- `wb_rd`  in  5  write-back destination
- `wb_data`  in  DATA_W  write-back value (already muxed memToReg)
- `sb_overflow`  out  1  sticky: issue attempted on saturated counter
- `sb_underflow`  out  1  sticky: retire on zero counter

## Operation
- Storage: NREG × DATA_W registers; counters `pend[i]` of CNT_W bits, one per register.
- Write: at posedge, if `wb_regWrite` && `wb_rd`≠0, `reg[wb_rd]` ← `wb_data`. Writes to index 0 are discarded, and index 0 always reads 0.
- Read: `rsN_data` = `reg[rsN_addr]`, combinational; bypass rules are in Configuration.
- Issue event `iss` = `issue_valid` && `issue_regWrite` && `issue_rd`≠0 && !`stall`.
- Retire event `ret` = `wb_regWrite` && `wb_rd`≠0.
- Counter update per register i, at posedge:
  - `iss` only to i: +1.
  - `ret` only to i: −1.
  - Both to i: unchanged.
- Saturation: `iss` to i with `pend[i]` = max → counter holds at max; `sb_overflow` sets.
- Underflow: `ret` to i with `pend[i]` = 0 and no simultaneous `iss` → counter holds at 0; `sb_underflow` sets.
- Sticky flags clear only on `rst`.
- Hazard for source N: `rsN_en` && `rsN_addr`≠0 && `pend[rsN_addr]` ≠ 0. The exception to this is covered in Configuration.
- `stall` = hazard1 | hazard2. It is independent of `issue_valid`.
- A stalled instruction never increments a counter.

## Timing
- Reset: all registers 0, all `pend` 0. `stall`=0, `sb_overflow`=0, `sb_underflow`=0. `rsN_data`=0 for all addresses.
- Reset asserted mid-operation clears all state immediately, regardless of clock.
- Read latency 0 (combinational). Write and counter latency 1 cycle (visible after the commit edge).
- Minimum producer→consumer spacing falls out of `stall`; no fixed cycle count is imposed.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Same-cycle write-to-read bypass: if `ret` && `wb_rd`==`rsN_addr`, then `rsN_data` = `wb_data`.
  - Hazard is suppressed when `pend[rsN_addr]`==1 and the retiring write targets `rsN_addr` this cycle.
- `REGFILE_BYPASS_EN` undefined:
  - No bypass; reads return the pre-edge register contents.
  - Hazard uses the raw `pend` value, so the consumer stalls through the retire cycle and reads one cycle later.

## Structure
- Shared package: `REG_IDX_W`=5, `ZERO_REG`=0, and the `reg_idx_t` typedef for register indices.
- One sub-module, `sb_counter`: a CNT_W up/down saturating counter with inc, dec, overflow and underflow pulses, instantiated NREG−1 times.

## Test plan
- Reset check: write `reg[5]`=0x1234, assert `rst` asynchronously → `rs1_data`(5)=0, `stall`=0, both flags 0.
- Basic write/read: `wb` x3←0xDEADBEEF, read x3 next cycle → 0xDEADBEEF. Write x0←0xFFFFFFFF → x0 reads 0.
- RAW stall: issue rd=7; next cycle `rs1_en`=1, `rs1_addr`=7 → `stall`=1. Then retire x7←0x55:
  - With bypass: `stall`=0 and `rs1_data`=0x55 in the retire cycle.
  - Without bypass: `stall`=1 in the retire cycle, then 0 with 0x55 one cycle later.
- Simultaneous issue and retire on x9 with `pend`=1 → `pend` stays 1 and `stall` stays asserted for readers of x9.
- Saturation: issue to x4 four times with no retire (CNT_W=2) → `pend`=3, `sb_overflow`=1. Retire x4 three times → `pend`=0. A fourth retire → `sb_underflow`=1.
- Disabled source: `rs2_en`=0, `rs2_addr`=4, `pend[4]`=2 → `stall`=0.
